pc_unit: RTL and testbench

Parametrised program-counter unit for the MIPS core: it owns the PC register and computes the next fetch address for sequential, branch, jump, register-jump and `eret` flow, and it produces the link value. It generalises the combinational next-PC logic with a configurable address width, reset PC and exception vector. It also owns the interrupt path: a pending-interrupt latch, an exception-level (EXL) mask and the EPC register. It sits between the controller (jump/branch decode, `pc_wr`) and instruction memory (`pc`).

---
 rtl/mips_pkg.sv | 9 +
 rtl/npc_calc.sv | 34 +++
 rtl/pc_unit.sv | 68 ++++++
 tb/tb_pc_unit.sv | 134 +++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared flow-select encodings and default PC constants for the fetch path
package mips_pkg;
  localparam logic [1:0] J_SEQ  = 2'b00;
  localparam logic [1:0] J_IMM  = 2'b01;
  localparam logic [1:0] J_REG  = 2'b10;
  localparam logic [1:0] J_ERET = 2'b11;
  localparam int unsigned RESET_PC_DEF = 'h0C00;
  localparam int unsigned EXC_VEC_DEF  = 'h1060;
endpackage

// File: rtl/npc_calc.sv
// npc_calc: combinational sequential/branch/jump/eret next-PC and link value
//   in:  pc, epc (word addresses), jump, npc_sel, zero, ins, imm16, busa
//   out: seq_npc (word address), jal_reg ({pc+1, 2'b00})
module npc_calc
  import mips_pkg::*;
#(
  parameter int DW = 32,
  localparam int AW = DW - 2
) (
  input  logic [AW-1:0] pc,
  input  logic [AW-1:0] epc,
  input  logic [1:0]    jump,
  input  logic          npc_sel,
  input  logic          zero,
  input  logic [DW-1:0] ins,
  input  logic [15:0]   imm16,
  input  logic [DW-1:0] busa,
  output logic [AW-1:0] seq_npc,
  output logic [DW-1:0] jal_reg
);
  logic [AW-1:0] pc_4;
  logic [AW-1:0] br_npc;
  logic          unused_bits;
  always_comb begin
    pc_4    = pc + AW'(1);
    br_npc  = (npc_sel & zero) ? pc_4 + {{(AW-16){imm16[15]}}, imm16} : pc_4;
    seq_npc = (jump == J_IMM) ? {pc_4[AW-1:AW-4], ins[AW-5:0]} :
              (jump == J_REG) ? busa[DW-1:2] :
              (jump == J_ERET) ? epc : br_npc;
    jal_reg = {pc_4, 2'b00};
  end
  // opcode bits and the byte offset of busa never reach the PC
  assign unused_bits = ^{ins[DW-1:AW-4], busa[1:0]};
endmodule

// File: rtl/pc_unit.sv
// pc_unit: PC register, next-PC selection, interrupt entry (pend/EXL/EPC) and eret return
//   in:  clk, rst (async high), pc_wr, jump, npc_sel, zero, ins, imm16, busa, irq
//   out: pc, npc, epc (word addresses), jal_reg, exl, irq_taken
module pc_unit
  import mips_pkg::*;
#(
  parameter int          DW       = 32,
  parameter int unsigned RESET_PC = RESET_PC_DEF,
  parameter int unsigned EXC_VEC  = EXC_VEC_DEF,
  localparam int AW = DW - 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pc_wr,
  input  logic [1:0]    jump,
  input  logic          npc_sel,
  input  logic          zero,
  input  logic [DW-1:0] ins,
  input  logic [15:0]   imm16,
  input  logic [DW-1:0] busa,
  input  logic          irq,
  output logic [AW-1:0] pc,
  output logic [AW-1:0] npc,
  output logic [DW-1:0] jal_reg,
  output logic [AW-1:0] epc,
  output logic          exl,
  output logic          irq_taken
);
  logic [AW-1:0] pc_q, pc_d, epc_q, epc_d, seq_npc;
  logic          exl_q, exl_d, pend_q, pend_d;
  npc_calc #(.DW(DW)) u_npc_calc (
    .pc      (pc_q),
    .epc     (epc_q),
    .jump    (jump),
    .npc_sel (npc_sel),
    .zero    (zero),
    .ins     (ins),
    .imm16   (imm16),
    .busa    (busa),
    .seq_npc (seq_npc),
    .jal_reg (jal_reg)
  );
  // eret outranks a pending interrupt; the interrupt then fires once exl has dropped
  always_comb begin
    irq_taken = (irq | pend_q) & ~exl_q & pc_wr & (jump != J_ERET);
    npc       = irq_taken ? AW'(EXC_VEC) : seq_npc;
    pc_d      = pc_wr ? npc : pc_q;
    epc_d     = irq_taken ? seq_npc : epc_q;
    exl_d     = irq_taken ? 1'b1 : (pc_wr && jump == J_ERET) ? 1'b0 : exl_q;
    pend_d    = irq_taken ? 1'b0 : pend_q | irq;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q   <= AW'(RESET_PC);
      epc_q  <= '0;
      exl_q  <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      epc_q  <= epc_d;
      exl_q  <= exl_d;
      pend_q <= pend_d;
    end
  end
  assign pc  = pc_q;
  assign epc = epc_q;
  assign exl = exl_q;
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed self-checking bench for pc_unit
module tb_pc_unit;
  logic        clk = 1'b0;
  logic        rst, pc_wr, npc_sel, zero, irq;
  logic [1:0]  jump;
  logic [31:0] ins, busa, jal_reg;
  logic [15:0] imm16;
  logic [29:0] pc, npc, epc;
  logic        exl, irq_taken;
  int passed = 0;
  int total  = 0;
  pc_unit dut (
    .clk(clk), .rst(rst), .pc_wr(pc_wr), .jump(jump), .npc_sel(npc_sel), .zero(zero),
    .ins(ins), .imm16(imm16), .busa(busa), .irq(irq), .pc(pc), .npc(npc),
    .jal_reg(jal_reg), .epc(epc), .exl(exl), .irq_taken(irq_taken)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1'b1; pc_wr = 1'b0; jump = 2'b00; npc_sel = 1'b0; zero = 1'b0;
    irq = 1'b0; ins = '0; busa = '0; imm16 = '0;
    #1;
    chk("rst_pc", 32'(pc), 32'h0C00);
    chk("rst_epc", 32'(epc), 32'h0);
    chk("rst_exl", 32'(exl), 32'h0);
    chk("rst_npc", 32'(npc), 32'h0C01);
    chk("rst_irqt", 32'(irq_taken), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    chk("rel_pc", 32'(pc), 32'h0C00);
    pc_wr = 1'b1;
    tick(); chk("seq1", 32'(pc), 32'h0C01);
    tick(); chk("seq2", 32'(pc), 32'h0C02);
    tick(); chk("seq3", 32'(pc), 32'h0C03);
    chk("jal_reg", jal_reg, 32'h3010);
    jump = 2'b10; busa = 32'h0000_3040; #1;
    chk("jr_npc", 32'(npc), 32'h0C10);
    tick(); chk("jr_pc", 32'(pc), 32'h0C10);
    jump = 2'b00; npc_sel = 1'b1; zero = 1'b1; imm16 = 16'hFFFE; #1;
    chk("br_taken", 32'(npc), 32'h0C0F);
    zero = 1'b0; #1;
    chk("br_not", 32'(npc), 32'h0C11);
    zero = 1'b1;
    tick(); chk("br_pc", 32'(pc), 32'h0C0F);
    npc_sel = 1'b0; jump = 2'b01; ins = 32'h0000_0C20;
    tick(); chk("j_pc", 32'(pc), 32'h0C20);
    jump = 2'b10; busa = 32'hC000_0000;
    tick(); chk("jr_hi", 32'(pc), 32'h3000_0000);
    jump = 2'b01; ins = 32'hFC00_0123;
    tick(); chk("j_region", 32'(pc), 32'h3000_0123);
    jump = 2'b10; busa = 32'hFFFF_FFFC;
    tick(); chk("jr_max", 32'(pc), 32'h3FFF_FFFF);
    jump = 2'b00; #1;
    chk("wrap_npc", 32'(npc), 32'h0);
    chk("wrap_jal", jal_reg, 32'h0);
    tick(); chk("wrap_pc", 32'(pc), 32'h0);
    jump = 2'b10; busa = 32'h0000_3010;
    tick(); chk("to_c04", 32'(pc), 32'h0C04);
    jump = 2'b00; pc_wr = 1'b0; irq = 1'b1; #1;
    chk("stall_noirq", 32'(irq_taken), 32'h0);
    tick(); irq = 1'b0;
    chk("stall_pc", 32'(pc), 32'h0C04);
    chk("stall_exl", 32'(exl), 32'h0);
    pc_wr = 1'b1; #1;
    chk("pend_taken", 32'(irq_taken), 32'h1);
    chk("vec_npc", 32'(npc), 32'h1060);
    tick();
    chk("vec_pc", 32'(pc), 32'h1060);
    chk("vec_epc", 32'(epc), 32'h0C05);
    chk("vec_exl", 32'(exl), 32'h1);
    chk("exl_mask", 32'(irq_taken), 32'h0);
    tick(); chk("hnd_pc", 32'(pc), 32'h1061);
    jump = 2'b11; #1;
    chk("eret_npc", 32'(npc), 32'h0C05);
    tick();
    chk("eret_pc", 32'(pc), 32'h0C05);
    chk("eret_exl", 32'(exl), 32'h0);
    jump = 2'b00; #1;
    chk("pend_clr", 32'(irq_taken), 32'h0);
    tick(); chk("post_pc", 32'(pc), 32'h0C06);
    irq = 1'b1;
    tick(); irq = 1'b0;
    chk("lvl_pc", 32'(pc), 32'h1060);
    chk("lvl_epc", 32'(epc), 32'h0C07);
    irq = 1'b1; #1;
    chk("exl_irq", 32'(irq_taken), 32'h0);
    tick(); irq = 1'b0;
    chk("exl_hold", 32'(pc), 32'h1061);
    jump = 2'b11; irq = 1'b1; #1;
    chk("eret_wins", 32'(irq_taken), 32'h0);
    tick(); irq = 1'b0;
    chk("eret2_pc", 32'(pc), 32'h0C07);
    chk("eret2_exl", 32'(exl), 32'h0);
    jump = 2'b00; #1;
    chk("pend_kept", 32'(irq_taken), 32'h1);
    tick();
    chk("pend_pc", 32'(pc), 32'h1060);
    chk("pend_epc", 32'(epc), 32'h0C08);
    jump = 2'b11;
    tick(); jump = 2'b00; #1;
    chk("collapse", 32'(irq_taken), 32'h0);
    chk("ret3_pc", 32'(pc), 32'h0C08);
    jump = 2'b11;
    tick();
    chk("eret0_pc", 32'(pc), 32'h0C08);
    chk("eret0_exl", 32'(exl), 32'h0);
    jump = 2'b00; irq = 1'b1;
    tick();
    chk("pre_epc", 32'(epc), 32'h0C09);
    tick(); irq = 1'b0;
    chk("pre_exl", 32'(exl), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("arst_pc", 32'(pc), 32'h0C00);
    chk("arst_epc", 32'(epc), 32'h0);
    chk("arst_exl", 32'(exl), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    chk("arst_noirq", 32'(irq_taken), 32'h0);
    tick();
    chk("arst_run", 32'(pc), 32'h0C01);
    chk("arst_exl2", 32'(exl), 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
